// File: rtl/axil_arbiter_if.sv
// Signal bundle around the two-requester AXI-lite arbiter: requester side (M0/M1)
// and transaction-engine side (AXIL_*), with views for the arbiter and its environment.
interface axil_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int BUS_WIDTH  = 32
);
   localparam int STRB_WIDTH = BUS_WIDTH / 8;

   logic                  M0_REQ;
   logic                  M1_REQ;
   logic                  M0_WE;
   logic                  M1_WE;
   logic [ADDR_WIDTH-1:0] M0_ADDR;
   logic [ADDR_WIDTH-1:0] M1_ADDR;
   logic [BUS_WIDTH-1:0]  M0_WDATA;
   logic [BUS_WIDTH-1:0]  M1_WDATA;
   logic [STRB_WIDTH-1:0] M0_WSTRB;
   logic [STRB_WIDTH-1:0] M1_WSTRB;
   logic                  M0_DONE;
   logic                  M1_DONE;
   logic [BUS_WIDTH-1:0]  M0_RDATA;
   logic [BUS_WIDTH-1:0]  M1_RDATA;

   logic                  AXIL_START_READ;
   logic                  AXIL_START_WRITE;
   logic [ADDR_WIDTH-1:0] AXIL_TRANSACTION_RADDR;
   logic [ADDR_WIDTH-1:0] AXIL_TRANSACTION_WRADDR;
   logic [BUS_WIDTH-1:0]  AXIL_TRANSACTION_WRDATA;
   logic [STRB_WIDTH-1:0] AXIL_TRANSACTION_WSTRB;
   logic                  AXIL_DONE_READ;
   logic                  AXIL_DONE_WRITE;
   logic [BUS_WIDTH-1:0]  AXIL_TRANSACTION_RDATA;

   logic                  BUSY;

   // Arbiter view: consumes requests and engine completions, produces grants and starts.
   modport slave (
      input  M0_REQ, M1_REQ, M0_WE, M1_WE, M0_ADDR, M1_ADDR,
      input  M0_WDATA, M1_WDATA, M0_WSTRB, M1_WSTRB,
      output M0_DONE, M1_DONE, M0_RDATA, M1_RDATA,
      output AXIL_START_READ, AXIL_START_WRITE,
      output AXIL_TRANSACTION_RADDR, AXIL_TRANSACTION_WRADDR,
      output AXIL_TRANSACTION_WRDATA, AXIL_TRANSACTION_WSTRB,
      input  AXIL_DONE_READ, AXIL_DONE_WRITE, AXIL_TRANSACTION_RDATA,
      output BUSY
   );

   // Environment view: the requesters and the transaction engine together.
   modport master (
      output M0_REQ, M1_REQ, M0_WE, M1_WE, M0_ADDR, M1_ADDR,
      output M0_WDATA, M1_WDATA, M0_WSTRB, M1_WSTRB,
      input  M0_DONE, M1_DONE, M0_RDATA, M1_RDATA,
      input  AXIL_START_READ, AXIL_START_WRITE,
      input  AXIL_TRANSACTION_RADDR, AXIL_TRANSACTION_WRADDR,
      input  AXIL_TRANSACTION_WRDATA, AXIL_TRANSACTION_WSTRB,
      output AXIL_DONE_READ, AXIL_DONE_WRITE, AXIL_TRANSACTION_RDATA,
      input  BUSY
   );
endinterface

// File: rtl/axil_arbiter.sv
// Round-robin arbiter letting two requesters share one AXI-lite transaction engine,
// one transaction outstanding at a time (IDLE -> ISSUE -> WAIT -> RESP).
module axil_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int BUS_WIDTH  = 32
) (
   input logic           CLK,
   input logic           RST_N,
   axil_arbiter_if.slave bus
);
   localparam int STRB_WIDTH = BUS_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic                  grant_q;
   logic                  grant_d;
   logic                  last_grant_q;
   logic                  last_grant_d;
   logic                  we_q;
   logic                  we_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic [BUS_WIDTH-1:0]  wdata_q;
   logic [BUS_WIDTH-1:0]  wdata_d;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic [STRB_WIDTH-1:0] wstrb_d;
   logic [BUS_WIDTH-1:0]  rdata_q;
   logic [BUS_WIDTH-1:0]  rdata_d;

   logic any_req;
   logic pick;
   logic engine_done;
   logic active;
   logic resp_m0;
   logic resp_m1;

   // Grant encoding: 0 = M0, 1 = M1. A tie goes to whoever was not served last.
   assign any_req     = bus.M0_REQ | bus.M1_REQ;
   assign pick        = (bus.M0_REQ & bus.M1_REQ) ? ~last_grant_q : bus.M1_REQ;
   assign engine_done = we_q ? bus.AXIL_DONE_WRITE : bus.AXIL_DONE_READ;
   assign active      = (state_q != IDLE);
   assign resp_m0     = (state_q == RESP) && !grant_q;
   assign resp_m1     = (state_q == RESP) &&  grant_q;

   // State and transaction registers; the pointer comes out of reset on M1 so M0 wins the first tie.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         rdata_q      <= rdata_d;
      end
   end

   // Next-state logic. The completion check is shared by ISSUE and WAIT so an engine
   // that answers in the same cycle as the start pulse skips WAIT entirely.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      rdata_d      = rdata_q;

      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d = pick;
               if (pick) begin
                  we_d    = bus.M1_WE;
                  addr_d  = bus.M1_ADDR;
                  wdata_d = bus.M1_WDATA;
                  wstrb_d = bus.M1_WSTRB;
               end else begin
                  we_d    = bus.M0_WE;
                  addr_d  = bus.M0_ADDR;
                  wdata_d = bus.M0_WDATA;
                  wstrb_d = bus.M0_WSTRB;
               end
               state_d = ISSUE;
            end
         end

         ISSUE, WAIT: begin
            if (engine_done) begin
               rdata_d      = we_q ? '0 : bus.AXIL_TRANSACTION_RDATA;
               last_grant_d = grant_q;
               state_d      = RESP;
            end else begin
               state_d = WAIT;
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decode purely from registered state, so reset clears them immediately.
   // The latched address/data appear only on the channel matching the latched op.
   always_comb begin
      bus.BUSY                    = active;
      bus.AXIL_START_READ         = (state_q == ISSUE) && !we_q;
      bus.AXIL_START_WRITE        = (state_q == ISSUE) &&  we_q;
      bus.AXIL_TRANSACTION_RADDR  = '0;
      bus.AXIL_TRANSACTION_WRADDR = '0;
      bus.AXIL_TRANSACTION_WRDATA = '0;
      bus.AXIL_TRANSACTION_WSTRB  = '0;
      if (active) begin
         if (we_q) begin
            bus.AXIL_TRANSACTION_WRADDR = addr_q;
            bus.AXIL_TRANSACTION_WRDATA = wdata_q;
            bus.AXIL_TRANSACTION_WSTRB  = wstrb_q;
         end else begin
            bus.AXIL_TRANSACTION_RADDR  = addr_q;
         end
      end
      bus.M0_DONE  = resp_m0;
      bus.M1_DONE  = resp_m1;
      bus.M0_RDATA = resp_m0 ? rdata_q : '0;
      bus.M1_RDATA = resp_m1 ? rdata_q : '0;
   end

   // Structural invariants: one start at a time, one completion at a time, never idle while answering.
   a_one_start: assert property (@(posedge CLK) disable iff (!RST_N)
      !(bus.AXIL_START_READ && bus.AXIL_START_WRITE));
   a_one_done: assert property (@(posedge CLK) disable iff (!RST_N)
      !(bus.M0_DONE && bus.M1_DONE));
   a_done_busy: assert property (@(posedge CLK) disable iff (!RST_N)
      (bus.M0_DONE || bus.M1_DONE) |-> bus.BUSY);

endmodule

// File: tb/tb_axil_arbiter.sv
// Self-checking bench for axil_arbiter: directed scenarios then randomized traffic,
// checked against a transaction-level model of the requesters and the engine.
module tb_axil_arbiter;
   localparam int ADDR_WIDTH = 32;
   localparam int BUS_WIDTH  = 32;

   logic CLK  = 1'b0;
   logic RST_N = 1'b0;

   always #5 CLK = ~CLK;

   axil_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH), .BUS_WIDTH(BUS_WIDTH)) bus ();

   axil_arbiter #(.ADDR_WIDTH(ADDR_WIDTH), .BUS_WIDTH(BUS_WIDTH)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   int assertCount = 0;
   int failCount   = 0;

   // Requester model: a pending transaction per requester plus the round-robin history.
   bit          pend   [2];
   bit          opWe   [2];
   logic [31:0] opAddr [2];
   logic [31:0] opWdata[2];
   logic [3:0]  opWstrb[2];
   int          lastGrant  = 1;
   int          dutGrant   = -1;

   // Every comparison funnels through here.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic nextCycle();
      @(posedge CLK);
      #1;
   endtask

   // Drive both requesters from the model's pending transactions.
   task automatic applyStimulus();
      bus.M0_REQ   = pend[0];
      bus.M0_WE    = opWe[0];
      bus.M0_ADDR  = opAddr[0];
      bus.M0_WDATA = opWdata[0];
      bus.M0_WSTRB = opWstrb[0];
      bus.M1_REQ   = pend[1];
      bus.M1_WE    = opWe[1];
      bus.M1_ADDR  = opAddr[1];
      bus.M1_WDATA = opWdata[1];
      bus.M1_WSTRB = opWstrb[1];
   endtask

   task automatic driveEngine(input bit doneR, input bit doneW, input logic [31:0] rdata);
      bus.AXIL_DONE_READ         = doneR;
      bus.AXIL_DONE_WRITE        = doneW;
      bus.AXIL_TRANSACTION_RDATA = rdata;
   endtask

   task automatic setOp(input int who, input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
      pend[who]    = 1'b1;
      opWe[who]    = we;
      opAddr[who]  = a;
      opWdata[who] = wd;
      opWstrb[who] = ws;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput($sformatf("%s BUSY", tag), bus.BUSY, 0);
      checkOutput($sformatf("%s START_READ", tag), bus.AXIL_START_READ, 0);
      checkOutput($sformatf("%s START_WRITE", tag), bus.AXIL_START_WRITE, 0);
      checkOutput($sformatf("%s RADDR", tag), bus.AXIL_TRANSACTION_RADDR, 0);
      checkOutput($sformatf("%s WRADDR", tag), bus.AXIL_TRANSACTION_WRADDR, 0);
      checkOutput($sformatf("%s WRDATA", tag), bus.AXIL_TRANSACTION_WRDATA, 0);
      checkOutput($sformatf("%s WSTRB", tag), bus.AXIL_TRANSACTION_WSTRB, 0);
      checkOutput($sformatf("%s M0_DONE", tag), bus.M0_DONE, 0);
      checkOutput($sformatf("%s M1_DONE", tag), bus.M1_DONE, 0);
      checkOutput($sformatf("%s M0_RDATA", tag), bus.M0_RDATA, 0);
      checkOutput($sformatf("%s M1_RDATA", tag), bus.M1_RDATA, 0);
   endtask

   // Expected view of a busy cycle: the granted op on its own channel, the other channel zero.
   task automatic checkBusy(input string tag, input bit expStartR, input bit expStartW,
                            input bit expDone0, input bit expDone1,
                            input logic [31:0] expRd0, input logic [31:0] expRd1,
                            input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
      checkOutput($sformatf("%s BUSY", tag), bus.BUSY, 1);
      checkOutput($sformatf("%s START_READ", tag), bus.AXIL_START_READ, expStartR);
      checkOutput($sformatf("%s START_WRITE", tag), bus.AXIL_START_WRITE, expStartW);
      checkOutput($sformatf("%s M0_DONE", tag), bus.M0_DONE, expDone0);
      checkOutput($sformatf("%s M1_DONE", tag), bus.M1_DONE, expDone1);
      checkOutput($sformatf("%s M0_RDATA", tag), bus.M0_RDATA, expRd0);
      checkOutput($sformatf("%s M1_RDATA", tag), bus.M1_RDATA, expRd1);
      checkOutput($sformatf("%s RADDR", tag), bus.AXIL_TRANSACTION_RADDR, we ? 32'h0 : a);
      checkOutput($sformatf("%s WRADDR", tag), bus.AXIL_TRANSACTION_WRADDR, we ? a : 32'h0);
      checkOutput($sformatf("%s WRDATA", tag), bus.AXIL_TRANSACTION_WRDATA, we ? wd : 32'h0);
      checkOutput($sformatf("%s WSTRB", tag), bus.AXIL_TRANSACTION_WSTRB, we ? ws : 4'h0);
   endtask

   // One full transaction, entered and left in an IDLE cycle. delay = cycles from START to engine DONE.
   task automatic runTransaction(input string name, input int delay, input logic [31:0] rd,
                                 input bit spurious, input bit dropReq,
                                 input bit scramble, input logic [31:0] scrAddr);
      int          g;
      bit          we;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  ws;
      logic [31:0] expR;
      checkOutput($sformatf("%s idle BUSY", name), bus.BUSY, 0);
      applyStimulus();
      if (pend[0] && pend[1]) g = 1 - lastGrant;
      else if (pend[1])       g = 1;
      else                    g = 0;
      we   = opWe[g];
      a    = opAddr[g];
      wd   = opWdata[g];
      ws   = opWstrb[g];
      expR = we ? 32'h0 : rd;

      nextCycle();
      driveEngine(0, 0, $urandom);
      checkBusy($sformatf("%s issue", name), !we, we, 0, 0, 0, 0, we, a, wd, ws);
      if (scramble) begin
         if (g == 0) begin bus.M0_ADDR = scrAddr; bus.M0_WDATA = $urandom; bus.M0_WSTRB = 4'($urandom); end
         else        begin bus.M1_ADDR = scrAddr; bus.M1_WDATA = $urandom; bus.M1_WSTRB = 4'($urandom); end
      end
      if (dropReq) begin
         if (g == 0) bus.M0_REQ = 1'b0;
         else        bus.M1_REQ = 1'b0;
      end
      if (delay == 0)    driveEngine(!we, we, rd);
      else if (spurious) driveEngine(we, !we, $urandom);

      for (int c = 1; c <= delay; c++) begin
         nextCycle();
         driveEngine(0, 0, $urandom);
         checkBusy($sformatf("%s wait%0d", name, c), 0, 0, 0, 0, 0, 0, we, a, wd, ws);
         if (c == delay)    driveEngine(!we, we, rd);
         else if (spurious) driveEngine(we, !we, $urandom);
      end

      nextCycle();
      driveEngine(0, 0, $urandom);
      dutGrant = bus.M1_DONE ? 1 : (bus.M0_DONE ? 0 : -1);
      checkBusy($sformatf("%s resp", name), 0, 0, g == 0, g == 1,
                (g == 0) ? expR : 32'h0, (g == 1) ? expR : 32'h0, we, a, wd, ws);

      nextCycle();
      pend[g]   = 1'b0;
      lastGrant = g;
      applyStimulus();
   endtask

   task automatic pulseReset();
      RST_N = 1'b0;
      nextCycle();
      checkAllZero("rst pulse");
      pend[0]   = 1'b0;
      pend[1]   = 1'b0;
      applyStimulus();
      RST_N     = 1'b1;
      lastGrant = 1;
   endtask

   int rrExpect[4] = '{0, 1, 0, 1};

   initial begin
      pend[0] = 0; pend[1] = 0;
      for (int i = 0; i < 2; i++) begin
         opWe[i] = 0; opAddr[i] = 0; opWdata[i] = 0; opWstrb[i] = 0;
      end
      applyStimulus();
      driveEngine(0, 0, 0);

      repeat (3) @(posedge CLK);
      #1;
      checkAllZero("reset");
      bus.M0_REQ = 1'b1;
      nextCycle();
      checkAllZero("reset with req");
      bus.M0_REQ = 1'b0;
      RST_N = 1'b1;

      $display("[TB] single M0 read, engine answers 3 cycles after start");
      setOp(0, 0, 32'h1000, 32'h0, 4'h0);
      runTransaction("m0 read", 3, 32'hDEADBEEF, 0, 0, 0, 0);

      $display("[TB] simultaneous requests from reset, four rounds");
      pulseReset();
      for (int k = 0; k < 4; k++) begin
         if (!pend[0]) setOp(0, 0, 32'h100 + k, 32'h0, 4'h0);
         if (!pend[1]) setOp(1, 1, 32'h200 + k, $urandom, 4'hF);
         runTransaction($sformatf("rr%0d", k), 1, $urandom, 0, 0, 0, 0);
         checkOutput($sformatf("rr%0d granted", k), dutGrant, rrExpect[k]);
      end
      runTransaction("rr drain", 1, $urandom, 0, 0, 0, 0);

      $display("[TB] M1 write with spurious read completions");
      setOp(1, 1, 32'h20, 32'h12345678, 4'hF);
      runTransaction("m1 write", 3, 32'hCAFEF00D, 1, 0, 0, 0);

      $display("[TB] engine completes in the start cycle");
      setOp(0, 0, 32'h40, 32'h0, 4'h0);
      runTransaction("fast read", 0, 32'h0BADF00D, 0, 0, 0, 0);
      checkOutput("fast read back idle", bus.BUSY, 0);

      $display("[TB] reset pulsed during WAIT");
      setOp(0, 0, 32'h3000, 32'h0, 4'h0);
      applyStimulus();
      nextCycle();
      checkOutput("rst mid issue START_READ", bus.AXIL_START_READ, 1);
      nextCycle();
      checkOutput("rst mid wait BUSY", bus.BUSY, 1);
      #2;
      RST_N = 1'b0;
      #1;
      checkAllZero("rst mid async");
      driveEngine(1, 0, 32'h55AA55AA);
      pend[0] = 0;
      applyStimulus();
      nextCycle();
      checkAllZero("rst mid held");
      driveEngine(0, 0, 0);
      RST_N     = 1'b1;
      lastGrant = 1;
      setOp(0, 0, 32'h3004, 32'h0, 4'h0);
      runTransaction("post rst read", 2, 32'h600DD00D, 0, 0, 0, 0);

      $display("[TB] requester changes address after grant");
      setOp(0, 0, 32'h1000, 32'h0, 4'h0);
      runTransaction("addr hold", 2, 32'hA5A5A5A5, 0, 0, 1, 32'h2000);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 60; n++) begin
         for (int i = 0; i < 2; i++)
            if (!pend[i] && ($urandom_range(0, 1) == 1))
               setOp(i, 1'($urandom), $urandom, $urandom, 4'($urandom));
         if (!pend[0] && !pend[1])
            setOp($urandom_range(0, 1), 1'($urandom), $urandom, $urandom, 4'($urandom));
         runTransaction($sformatf("rand%0d", n), $urandom_range(0, 4), $urandom,
                        1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin
      #200000;
      failCount++;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
